// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO round-robin arbiter: state encoding and sizing helpers.
package fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo NREQ.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            valid,
  output logic [PW-1:0]   idx
);

  logic [PW-1:0] cand;

  // Scan ptr+1 .. ptr+NREQ so the previous owner is considered last.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arb.sv
// Merges NREQ zero-latency FIFOs into one downstream FIFO, granting owners round-robin
// either in bursts of up to BURST words (PKT=0) or whole eop-terminated packets (PKT=1).
module fifo_rr_arb
  import fifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DATAWIDTH = 18,
  parameter int BURST     = 8,
  parameter int PKT       = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           in_ne,
  input  logic [NREQ*DATAWIDTH-1:0] in_data,
  output logic [NREQ-1:0]           in_re,
  input  logic                      out_full,
  output logic [DATAWIDTH-1:0]      out_data,
  output logic                      out_we,
  output logic [NREQ-1:0]           grant,
  output logic                      busy
);

  localparam int PW = idx_width(NREQ);
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_M1 = CW'(BURST - 1);

  arb_state_t          state, state_nx;
  logic [PW-1:0]       ptr, ptr_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [NREQ-1:0]     grant_nx;
  logic                busy_nx;

  logic [NREQ-1:0]     pick_gnt;
  logic                pick_valid;
  logic [PW-1:0]       pick_idx;

  logic [DATAWIDTH-1:0] data_arr [NREQ];
  logic [DATAWIDTH-1:0] owner_data;
  logic                 owner_ne;
  logic                 owner_eop;
  logic                 pop;
  logic                 leave;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = in_data[i*DATAWIDTH +: DATAWIDTH];
  end

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (in_ne),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // While in XFER, ptr always names the current owner.
  assign owner_data = data_arr[ptr];
  assign owner_ne   = in_ne[ptr];
  assign owner_eop  = owner_data[DATAWIDTH-1];
  assign pop        = (state == XFER) && owner_ne && !out_full && !reset;

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    grant_nx = grant;
    busy_nx  = busy;
    in_re    = '0;
    leave    = 1'b0;

    if (pop) begin
      in_re[ptr] = 1'b1;
    end

    case (state)
      IDLE: begin
        if (pick_valid && !out_full) begin
          state_nx = XFER;
          ptr_nx   = pick_idx;
          grant_nx = pick_gnt;
          busy_nx  = 1'b1;
          cnt_nx   = '0;
        end
      end
      XFER: begin
        if (pop) begin
          cnt_nx = cnt + 1'b1;
        end
        // Burst mode also ends as soon as the owner runs dry; packet mode waits for eop.
        if (PKT != 0) begin
          leave = pop && owner_eop;
        end else begin
          leave = !owner_ne || (pop && (cnt == BURST_M1));
        end
        if (leave) begin
          state_nx = IDLE;
          grant_nx = '0;
          busy_nx  = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= PW'(NREQ - 1);
      cnt      <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      out_we   <= 1'b0;
      out_data <= '0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      cnt    <= cnt_nx;
      grant  <= grant_nx;
      busy   <= busy_nx;
      out_we <= pop;
      if (pop) begin
        out_data <= owner_data;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_arb.sv
// Directed bench for fifo_rr_arb: burst mode on one instance, packet mode on a second.
module tb_fifo_rr_arb;

  typedef logic [17:0] word_t;

  logic        clk;
  logic        reset;
  logic        out_full;

  logic [3:0]  ne_a, re_a, grant_a;
  logic [71:0] data_a;
  logic [17:0] out_data_a;
  logic        out_we_a, busy_a;

  logic [3:0]  ne_p, re_p, grant_p;
  logic [71:0] data_p;
  logic [17:0] out_data_p;
  logic        out_we_p, busy_p;
  logic        full_p;

  word_t qa [4][$];
  word_t qp [4][$];
  logic [3:0] gap_p;
  int next_seq [4];

  int total_cnt;
  int pass_cnt;
  int fail_cnt;

  fifo_rr_arb #(.NREQ(4), .DATAWIDTH(18), .BURST(8), .PKT(0)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .in_ne    (ne_a),
    .in_data  (data_a),
    .in_re    (re_a),
    .out_full (out_full),
    .out_data (out_data_a),
    .out_we   (out_we_a),
    .grant    (grant_a),
    .busy     (busy_a)
  );

  fifo_rr_arb #(.NREQ(4), .DATAWIDTH(18), .BURST(8), .PKT(1)) u_pkt (
    .clk      (clk),
    .reset    (reset),
    .in_ne    (ne_p),
    .in_data  (data_p),
    .in_re    (re_p),
    .out_full (full_p),
    .out_data (out_data_p),
    .out_we   (out_we_p),
    .grant    (grant_p),
    .busy     (busy_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t mk(input int r, input int s, input bit eop);
    return {eop, 4'(r), 13'(s)};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      ne_a[i] = (qa[i].size() > 0);
      data_a[i*18 +: 18] = (qa[i].size() > 0) ? qa[i][0] : '0;
      ne_p[i] = (qp[i].size() > 0) && !gap_p[i];
      data_p[i*18 +: 18] = (qp[i].size() > 0) ? qp[i][0] : '0;
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic full);
    reset    = rst;
    out_full = full;
    refresh();
    #1;
  endtask

  // One clock: pops follow the in_re seen just before the edge, like a zero-latency FIFO.
  task automatic tick();
    logic [3:0] ra, rp;
    ra = re_a;
    rp = re_p;
    if (ra != 4'b0) check_output("re_onehot_a", 32'($onehot0(ra)), 32'd1);
    if (rp != 4'b0) check_output("re_onehot_p", 32'($onehot0(rp)), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (ra[i]) begin
        check_output("no_underflow_a", 32'(qa[i].size() > 0), 32'd1);
        if (qa[i].size() > 0) void'(qa[i].pop_front());
      end
      if (rp[i]) begin
        check_output("no_underflow_p", 32'(qp[i].size() > 0), 32'd1);
        if (qp[i].size() > 0) void'(qp[i].pop_front());
      end
    end
    refresh();
    #1;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < 4; i++) begin
      qa[i].delete();
      qp[i].delete();
      next_seq[i] = 0;
    end
    gap_p = '0;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    fail_cnt  = 0;
    full_p    = 1'b0;
    clear_queues();

    // Reset with requests present: nothing granted, nothing popped.
    qa[1].push_back(mk(1, 0, 1'b0));
    apply_stimulus(1'b1, 1'b0);
    check_output("reset_re", 32'(re_a), 32'h0);
    tick();
    check_output("reset_grant", 32'(grant_a), 32'h0);
    check_output("reset_busy", 32'(busy_a), 32'h0);
    check_output("reset_we", 32'(out_we_a), 32'h0);
    check_output("reset_data", 32'(out_data_a), 32'h0);
    check_output("reset_grant_p", 32'(grant_p), 32'h0);
    clear_queues();

    // Lone requester 2 with three words.
    apply_stimulus(1'b0, 1'b0);
    for (int s = 0; s < 3; s++) qa[2].push_back(mk(2, s, 1'b0));
    apply_stimulus(1'b0, 1'b0);
    check_output("idle_no_pop", 32'(re_a), 32'h0);
    tick();
    check_output("r2_grant", 32'(grant_a), 32'h4);
    check_output("r2_busy", 32'(busy_a), 32'h1);
    check_output("r2_re", 32'(re_a), 32'h4);
    for (int s = 0; s < 3; s++) begin
      tick();
      check_output("r2_we", 32'(out_we_a), 32'h1);
      check_output("r2_data", 32'(out_data_a), 32'(mk(2, s, 1'b0)));
    end
    check_output("r2_dry_re", 32'(re_a), 32'h0);
    tick();
    check_output("r2_idle_grant", 32'(grant_a), 32'h0);
    check_output("r2_idle_we", 32'(out_we_a), 32'h0);
    check_output("r2_hold_data", 32'(out_data_a), 32'(mk(2, 2, 1'b0)));
    tick();
    check_output("r2_idle_stays", 32'(grant_a), 32'h0);

    // All four continuously ready: grants 0,1,2,3,0 with eight words each.
    apply_stimulus(1'b1, 1'b0);
    tick();
    check_output("rst2_data", 32'(out_data_a), 32'h0);
    for (int i = 0; i < 4; i++)
      for (int s = 0; s < 20; s++) qa[i].push_back(mk(i, s, 1'b0));
    apply_stimulus(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      int o;
      o = k % 4;
      tick();
      check_output("rr_grant", 32'(grant_a), 32'(1 << o));
      check_output("rr_bubble_we", 32'(out_we_a), 32'h0);
      for (int n = 0; n < 8; n++) begin
        tick();
        check_output("rr_we", 32'(out_we_a), 32'h1);
        check_output("rr_data", 32'(out_data_a), 32'(mk(o, next_seq[o], 1'b0)));
        next_seq[o]++;
      end
      check_output("rr_end_grant", 32'(grant_a), 32'h0);
    end

    // Requester 1 burst stalled by out_full for four cycles.
    tick();
    check_output("st_grant", 32'(grant_a), 32'h2);
    for (int n = 0; n < 3; n++) begin
      tick();
      check_output("st_data_pre", 32'(out_data_a), 32'(mk(1, next_seq[1], 1'b0)));
      next_seq[1]++;
    end
    apply_stimulus(1'b0, 1'b1);
    check_output("st_re_same_cycle", 32'(re_a), 32'h0);
    for (int n = 0; n < 4; n++) begin
      tick();
      check_output("st_we", 32'(out_we_a), 32'h0);
      check_output("st_grant_held", 32'(grant_a), 32'h2);
      check_output("st_data_hold", 32'(out_data_a), 32'(mk(1, 10, 1'b0)));
    end
    apply_stimulus(1'b0, 1'b0);
    check_output("st_resume_re", 32'(re_a), 32'h2);
    for (int n = 0; n < 5; n++) begin
      tick();
      check_output("st_we_post", 32'(out_we_a), 32'h1);
      check_output("st_data_post", 32'(out_data_a), 32'(mk(1, next_seq[1], 1'b0)));
      next_seq[1]++;
    end
    check_output("st_end_grant", 32'(grant_a), 32'h0);
    apply_stimulus(1'b0, 1'b1);
    tick();
    check_output("full_idle_grant", 32'(grant_a), 32'h0);
    check_output("full_idle_busy", 32'(busy_a), 32'h0);
    apply_stimulus(1'b0, 1'b0);
    tick();
    check_output("full_rel_grant", 32'(grant_a), 32'h4);

    // Reset while requester 2 is about to pop its third word.
    for (int n = 0; n < 2; n++) begin
      tick();
      check_output("rx_data", 32'(out_data_a), 32'(mk(2, next_seq[2], 1'b0)));
      next_seq[2]++;
    end
    apply_stimulus(1'b1, 1'b0);
    check_output("rx_re", 32'(re_a), 32'h0);
    tick();
    check_output("rx_grant", 32'(grant_a), 32'h0);
    check_output("rx_we", 32'(out_we_a), 32'h0);
    check_output("rx_busy", 32'(busy_a), 32'h0);
    check_output("rx_no_pop", 32'(qa[2].size()), 32'd10);
    apply_stimulus(1'b0, 1'b0);
    tick();
    check_output("rx_first_grant", 32'(grant_a), 32'h1);
    tick();
    check_output("rx_first_data", 32'(out_data_a), 32'(mk(0, 16, 1'b0)));

    // Single requester with more than one burst is regranted after one idle cycle.
    apply_stimulus(1'b1, 1'b0);
    clear_queues();
    tick();
    for (int s = 0; s < 10; s++) qa[3].push_back(mk(3, s, 1'b0));
    apply_stimulus(1'b0, 1'b0);
    tick();
    check_output("solo_grant", 32'(grant_a), 32'h8);
    for (int n = 0; n < 8; n++) begin
      tick();
      check_output("solo_data", 32'(out_data_a), 32'(mk(3, n, 1'b0)));
    end
    check_output("solo_idle", 32'(grant_a), 32'h0);
    tick();
    check_output("solo_regrant", 32'(grant_a), 32'h8);
    for (int n = 8; n < 10; n++) begin
      tick();
      check_output("solo_data2", 32'(out_data_a), 32'(mk(3, n, 1'b0)));
    end
    tick();
    check_output("solo_dry_grant", 32'(grant_a), 32'h0);
    check_output("solo_dry_we", 32'(out_we_a), 32'h0);
    check_output("solo_dry_data", 32'(out_data_a), 32'(mk(3, 9, 1'b0)));

    // Packet mode: requester 1 holds the grant across an empty gap until eop.
    apply_stimulus(1'b1, 1'b0);
    clear_queues();
    tick();
    for (int s = 0; s < 5; s++) qp[1].push_back(mk(1, s, s == 4));
    apply_stimulus(1'b0, 1'b0);
    tick();
    check_output("pk_grant", 32'(grant_p), 32'h2);
    qp[0].push_back(mk(0, 0, 1'b0));
    qp[0].push_back(mk(0, 1, 1'b1));
    apply_stimulus(1'b0, 1'b0);
    for (int s = 0; s < 2; s++) begin
      tick();
      check_output("pk_data_pre", 32'(out_data_p), 32'(mk(1, s, 1'b0)));
    end
    gap_p[1] = 1'b1;
    apply_stimulus(1'b0, 1'b0);
    check_output("pk_gap_re", 32'(re_p), 32'h0);
    for (int n = 0; n < 3; n++) begin
      tick();
      check_output("pk_gap_we", 32'(out_we_p), 32'h0);
      check_output("pk_gap_grant", 32'(grant_p), 32'h2);
      check_output("pk_gap_busy", 32'(busy_p), 32'h1);
    end
    gap_p[1] = 1'b0;
    apply_stimulus(1'b0, 1'b0);
    for (int s = 2; s < 5; s++) begin
      tick();
      check_output("pk_we_post", 32'(out_we_p), 32'h1);
      check_output("pk_data_post", 32'(out_data_p), 32'(mk(1, s, s == 4)));
    end
    check_output("pk_eop_idle", 32'(grant_p), 32'h0);
    tick();
    check_output("pk_r0_grant", 32'(grant_p), 32'h1);
    tick();
    check_output("pk_r0_data0", 32'(out_data_p), 32'(mk(0, 0, 1'b0)));
    tick();
    check_output("pk_r0_data1", 32'(out_data_p), 32'(mk(0, 1, 1'b1)));
    check_output("pk_r0_done", 32'(grant_p), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
